// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and elaboration helpers for the arbitrated stream mux
package mux_pkg;

   typedef enum logic {
      OCIOSO  = 1'b0,
      TRAVADO = 1'b1
   } estado_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Pointer starts on the last channel so the first scan lands on channel 0.
   function automatic int reset_ptr(input int entradas);
      return entradas - 1;
   endfunction

endpackage

// File: rtl/mux_fluxo_arbitrado_arbitro_rr.sv
// rtl/mux_fluxo_arbitrado_arbitro_rr.sv - combinational round-robin picker
// Scans ptr+1, ptr+2, ... (wrapping) and reports the first requesting channel.
module arbitro_rr
   import mux_pkg::*;
#(
   parameter  int ENTRADAS = 4,
   localparam int SEL_W    = clog2(ENTRADAS)
) (
   input  logic [ENTRADAS-1:0] pedidos,
   input  logic [SEL_W-1:0]    ptr,
   output logic                concedido,
   output logic [SEL_W-1:0]    canal
);

   always_comb begin
      concedido = 1'b0;
      canal     = '0;
      for (int k = 1; k <= ENTRADAS; k++) begin
         if (!concedido && pedidos[(int'(ptr) + k) % ENTRADAS]) begin
            concedido = 1'b1;
            canal     = SEL_W'((int'(ptr) + k) % ENTRADAS);
         end
      end
   end

endmodule

// File: rtl/mux_fluxo_arbitrado.sv
// rtl/mux_fluxo_arbitrado.sv - N:1 packet-locked stream mux with registered output
// Arbitrates in OCIOSO (selector or round-robin), then streams one packet in TRAVADO.
module mux_fluxo_arbitrado
   import mux_pkg::*;
#(
   parameter  int LARGURA  = 32,
   parameter  int ENTRADAS = 4,
   parameter  int MODO     = 1,
   localparam int SEL_W    = clog2(ENTRADAS)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [ENTRADAS*LARGURA-1:0] entrada_dados,
   input  logic [ENTRADAS-1:0]         entrada_valido,
   input  logic [ENTRADAS-1:0]         entrada_ultimo,
   output logic [ENTRADAS-1:0]         entrada_pronto,
   input  logic [SEL_W-1:0]            seletor,
   output logic [LARGURA-1:0]          saida_dados,
   output logic                        saida_valido,
   output logic                        saida_ultimo,
   output logic [SEL_W-1:0]            saida_canal,
   input  logic                        saida_pronto
);

   estado_t            estado_q, estado_d;
   logic [SEL_W-1:0]   canal_q, canal_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [LARGURA-1:0] dados_q, dados_d;
   logic               valido_q, valido_d;
   logic               ultimo_q, ultimo_d;
   logic [SEL_W-1:0]   saida_canal_q, saida_canal_d;

   logic               rr_concedido;
   logic [SEL_W-1:0]   rr_canal;
   logic               sel_concedido;
   logic               concedido;
   logic [SEL_W-1:0]   canal_novo;
   logic               pronto_canal;
   logic               transfere;

   arbitro_rr #(.ENTRADAS(ENTRADAS)) u_arbitro (
      .pedidos   (entrada_valido),
      .ptr       (ptr_q),
      .concedido (rr_concedido),
      .canal     (rr_canal)
   );

   // An out-of-range selector shifts the mask off the end, so it never grants.
   assign sel_concedido = (int'(seletor) < ENTRADAS) &&
                          (|(entrada_valido & (ENTRADAS'(1) << seletor)));

   assign concedido  = (MODO == 0) ? sel_concedido : rr_concedido;
   assign canal_novo = (MODO == 0) ? seletor       : rr_canal;

   assign pronto_canal   = (estado_q == TRAVADO) && (!valido_q || saida_pronto);
   assign transfere      = pronto_canal && entrada_valido[canal_q];
   assign entrada_pronto = pronto_canal ? (ENTRADAS'(1) << canal_q) : '0;

   always_comb begin
      estado_d      = estado_q;
      canal_d       = canal_q;
      ptr_d         = ptr_q;
      dados_d       = dados_q;
      valido_d      = valido_q;
      ultimo_d      = ultimo_q;
      saida_canal_d = saida_canal_q;

      case (estado_q)
         OCIOSO: begin
            if (concedido) begin
               canal_d  = canal_novo;
               estado_d = TRAVADO;
            end
         end
         TRAVADO: begin
            if (transfere && entrada_ultimo[canal_q]) begin
               estado_d = OCIOSO;
               if (MODO == 1) ptr_d = canal_q;
            end
         end
         default: estado_d = OCIOSO;
      endcase

      // Output register: load on a beat, otherwise drain when the consumer takes it.
      if (transfere) begin
         dados_d       = entrada_dados[int'(canal_q)*LARGURA +: LARGURA];
         ultimo_d      = entrada_ultimo[canal_q];
         saida_canal_d = canal_q;
         valido_d      = 1'b1;
      end else if (saida_pronto) begin
         valido_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado_q      <= OCIOSO;
         canal_q       <= '0;
         ptr_q         <= SEL_W'(reset_ptr(ENTRADAS));
         dados_q       <= '0;
         valido_q      <= 1'b0;
         ultimo_q      <= 1'b0;
         saida_canal_q <= '0;
      end else begin
         estado_q      <= estado_d;
         canal_q       <= canal_d;
         ptr_q         <= ptr_d;
         dados_q       <= dados_d;
         valido_q      <= valido_d;
         ultimo_q      <= ultimo_d;
         saida_canal_q <= saida_canal_d;
      end
   end

   assign saida_dados  = dados_q;
   assign saida_valido = valido_q;
   assign saida_ultimo = ultimo_q;
   assign saida_canal  = saida_canal_q;

endmodule

// File: tb/tb_mux_fluxo_arbitrado.sv
// tb/tb_mux_fluxo_arbitrado.sv - scoreboard bench for mux_fluxo_arbitrado
// Per-channel expected-beat queues; a monitor pops them as the consumer accepts output beats.
module tb_mux_fluxo_arbitrado;

   localparam int N  = 4;
   localparam int NB = 3;
   localparam int W  = 32;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic [N*W-1:0] entrada_dados;
   logic [N-1:0]   entrada_valido, entrada_ultimo, entrada_pronto;
   logic [1:0]     seletor;
   logic [W-1:0]   saida_dados;
   logic           saida_valido, saida_ultimo, saida_pronto;
   logic [1:0]     saida_canal;

   logic [NB*W-1:0] b_entrada_dados;
   logic [NB-1:0]   b_entrada_valido, b_entrada_ultimo, b_entrada_pronto;
   logic [1:0]      b_seletor;
   logic [W-1:0]    b_saida_dados;
   logic            b_saida_valido, b_saida_ultimo, b_saida_pronto;
   logic [1:0]      b_saida_canal;

   mux_fluxo_arbitrado #(.LARGURA(W), .ENTRADAS(N), .MODO(1)) dut_rr (
      .clock(clock), .reset_n(reset_n),
      .entrada_dados(entrada_dados), .entrada_valido(entrada_valido),
      .entrada_ultimo(entrada_ultimo), .entrada_pronto(entrada_pronto),
      .seletor(seletor), .saida_dados(saida_dados), .saida_valido(saida_valido),
      .saida_ultimo(saida_ultimo), .saida_canal(saida_canal), .saida_pronto(saida_pronto)
   );

   mux_fluxo_arbitrado #(.LARGURA(W), .ENTRADAS(NB), .MODO(0)) dut_sel (
      .clock(clock), .reset_n(reset_n),
      .entrada_dados(b_entrada_dados), .entrada_valido(b_entrada_valido),
      .entrada_ultimo(b_entrada_ultimo), .entrada_pronto(b_entrada_pronto),
      .seletor(b_seletor), .saida_dados(b_saida_dados), .saida_valido(b_saida_valido),
      .saida_ultimo(b_saida_ultimo), .saida_canal(b_saida_canal), .saida_pronto(b_saida_pronto)
   );

   typedef struct packed {
      logic [W-1:0] dados;
      logic         ultimo;
   } beat_t;

   beat_t    pend[N][$];
   beat_t    esp[N][$];
   int       ord_ch[$];
   int       ord_t[$];
   int       testes = 0;
   int       falhas = 0;
   int       vistos = 0;
   int       ciclo  = 0;
   int       sp_modo = 1;
   bit       bolha = 1'b0;
   logic [N-1:0] acc;

   task automatic checar(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
      testes++;
      if (atual !== esperado) begin
         falhas++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   task automatic ciclo_tb();
      @(negedge clock);
      #3;
   endtask

   task automatic push_beat(input int c, input logic [W-1:0] d, input logic u);
      beat_t b;
      b.dados  = d;
      b.ultimo = u;
      pend[c].push_back(b);
      esp[c].push_back(b);
   endtask

   task automatic push_pacote(input int c, input int len);
      for (int i = 0; i < len; i++) push_beat(c, $urandom, (i == len - 1));
   endtask

   function automatic int pendentes();
      int s = 0;
      for (int c = 0; c < N; c++) s += esp[c].size();
      return s;
   endfunction

   task automatic esperar_vazio(input int limite);
      int n = 0;
      while (pendentes() > 0 && n < limite) begin
         ciclo_tb();
         n++;
      end
      testes++;
      if (pendentes() > 0) begin
         falhas++;
         $display("FAIL drain: %0d beats still expected after %0d cycles, required 0", pendentes(), limite);
      end
   endtask

   task automatic esperar_vistos(input int alvo, input string nome);
      int n = 0;
      while (vistos < alvo && n < 200) begin
         ciclo_tb();
         n++;
      end
      testes++;
      if (vistos < alvo) begin
         falhas++;
         $display("FAIL %s: saw %0d beats, required %0d", nome, vistos, alvo);
      end
   endtask

   // Producer model: each channel offers the head of its queue; acceptance is latched before the edge.
   initial begin
      entrada_valido = '0;
      entrada_ultimo = '0;
      entrada_dados  = '0;
      saida_pronto   = 1'b0;
      acc            = '0;
      forever begin
         @(negedge clock);
         for (int c = 0; c < N; c++) begin
            if (acc[c] && pend[c].size() > 0) void'(pend[c].pop_front());
            if (pend[c].size() > 0 && !(bolha && $urandom_range(3) == 0)) begin
               entrada_valido[c]       = 1'b1;
               entrada_dados[c*W +: W] = pend[c][0].dados;
               entrada_ultimo[c]       = pend[c][0].ultimo;
            end else begin
               entrada_valido[c]       = 1'b0;
               entrada_ultimo[c]       = 1'b0;
               entrada_dados[c*W +: W] = '0;
            end
         end
         case (sp_modo)
            0:       saida_pronto = ($urandom_range(1) == 1);
            1:       saida_pronto = 1'b1;
            default: saida_pronto = 1'b0;
         endcase
         #1 acc = entrada_valido & entrada_pronto;
      end
   end

   // Monitor: every beat the consumer accepts is matched against its channel's queue.
   initial begin
      bit    em_pacote;
      bit    segura;
      int    canal_pkt;
      int    c;
      beat_t e;
      em_pacote = 1'b0;
      segura    = 1'b0;
      canal_pkt = 0;
      forever begin
         @(negedge clock);
         #2;
         ciclo++;
         if (!reset_n) begin
            em_pacote = 1'b0;
            segura    = 1'b0;
         end else begin
            if (segura) checar("hold_valido", saida_valido, 1);
            segura = saida_valido && !saida_pronto;
            if (saida_valido && saida_pronto) begin
               c = int'(saida_canal);
               if (em_pacote) checar("packet_lock_canal", c, canal_pkt);
               if (esp[c].size() == 0) begin
                  testes++;
                  falhas++;
                  $display("FAIL extra_beat: canal %0d dados %0h, required no beat", c, saida_dados);
               end else begin
                  e = esp[c].pop_front();
                  checar("saida_dados", saida_dados, e.dados);
                  checar("saida_ultimo", saida_ultimo, e.ultimo);
               end
               em_pacote = !saida_ultimo;
               canal_pkt = c;
               ord_ch.push_back(c);
               ord_t.push_back(ciclo);
               vistos++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_rr[5]   = '{0, 1, 2, 3, 0};
      int exp_lock[4] = '{2, 2, 2, 0};
      int dt_lock[4]  = '{0, 1, 1, 2};
      int s0;
      int base;

      reset_n          = 1'b0;
      seletor          = '0;
      b_entrada_dados  = '0;
      b_entrada_valido = '0;
      b_entrada_ultimo = '0;
      b_seletor        = '0;
      b_saida_pronto   = 1'b1;

      repeat (2) @(negedge clock);
      #3;
      checar("reset_saida_valido", saida_valido, 0);
      checar("reset_entrada_pronto", entrada_pronto, 0);
      checar("reset_saida_canal", saida_canal, 0);
      checar("reset_saida_dados", saida_dados, 0);
      checar("reset_b_saida_valido", b_saida_valido, 0);
      reset_n = 1'b1;

      // Round-robin with 1-beat packets, all channels offered together.
      s0 = ord_ch.size();
      push_pacote(0, 1);
      push_pacote(0, 1);
      for (int c = 1; c < N; c++) push_pacote(c, 1);
      esperar_vazio(200);
      ciclo_tb();
      if (ord_ch.size() < s0 + 5) checar("rr_beats", ord_ch.size() - s0, 5);
      else begin
         for (int i = 0; i < 5; i++) begin
            checar("rr_canal", ord_ch[s0+i], exp_rr[i]);
            if (i > 0) checar("rr_intervalo", ord_t[s0+i] - ord_t[s0+i-1], 2);
         end
      end

      // Packet lock: channel 2 streams three beats while channel 0 waits.
      s0 = ord_ch.size();
      push_beat(2, 32'hA1, 1'b0);
      push_beat(2, 32'hA2, 1'b0);
      push_beat(2, 32'hA3, 1'b1);
      push_beat(0, 32'hB0, 1'b1);
      esperar_vazio(200);
      ciclo_tb();
      if (ord_ch.size() < s0 + 4) checar("lock_beats", ord_ch.size() - s0, 4);
      else begin
         for (int i = 0; i < 4; i++) begin
            checar("lock_canal", ord_ch[s0+i], exp_lock[i]);
            if (i > 0) checar("lock_intervalo", ord_t[s0+i] - ord_t[s0+i-1], dt_lock[i]);
         end
      end

      // Backpressure mid-packet for five cycles.
      base = vistos;
      push_pacote(1, 4);
      esperar_vistos(base + 1, "bp_first_beat");
      sp_modo = 2;
      for (int i = 0; i < 5; i++) begin
         ciclo_tb();
         if (i == 2) begin
            checar("bp_entrada_pronto", entrada_pronto, 0);
            checar("bp_saida_valido", saida_valido, 1);
         end
      end
      sp_modo = 1;
      esperar_vazio(200);
      checar("bp_total_beats", vistos - base, 4);

      // Reset after beat 2 of 4: remaining beats are discarded.
      ciclo_tb();
      base = vistos;
      push_pacote(3, 4);
      esperar_vistos(base + 2, "rst_two_beats");
      reset_n = 1'b0;
      pend[3].delete();
      esp[3].delete();
      ciclo_tb();
      checar("rst_mid_saida_valido", saida_valido, 0);
      checar("rst_mid_entrada_pronto", entrada_pronto, 0);
      checar("rst_mid_saida_ultimo", saida_ultimo, 0);
      reset_n = 1'b1;
      repeat (10) ciclo_tb();
      checar("rst_mid_beats", vistos - base, 2);
      checar("rst_mid_idle_pronto", entrada_pronto, 0);

      // Randomised traffic with valid bubbles and random consumer stalls.
      bolha   = 1'b1;
      sp_modo = 0;
      for (int p = 0; p < 40; p++) begin
         push_pacote($urandom_range(N-1), $urandom_range(1, 4));
         repeat ($urandom_range(0, 3)) ciclo_tb();
      end
      esperar_vazio(3000);
      bolha   = 1'b0;
      sp_modo = 1;
      repeat (3) ciclo_tb();

      // Selector mode, 3 channels.
      b_seletor                = 2'd3;
      b_entrada_valido         = 3'b010;
      b_entrada_dados[W +: W]  = 32'hC1;
      b_entrada_ultimo         = 3'b000;
      repeat (3) ciclo_tb();
      checar("b_sel3_pronto", b_entrada_pronto, 0);
      checar("b_sel3_valido", b_saida_valido, 0);
      b_seletor = 2'd1;
      ciclo_tb();
      checar("b_grant1_pronto", b_entrada_pronto, 3'b010);
      b_seletor               = 2'd0;
      b_entrada_valido        = 3'b011;
      b_entrada_dados[0 +: W] = 32'hD0;
      b_entrada_ultimo        = 3'b001;
      ciclo_tb();
      checar("b_beat1_dados", b_saida_dados, 32'hC1);
      checar("b_beat1_canal", b_saida_canal, 1);
      checar("b_beat1_ultimo", b_saida_ultimo, 0);
      b_entrada_dados[W +: W] = 32'hC2;
      b_entrada_ultimo        = 3'b011;
      ciclo_tb();
      checar("b_beat2_dados", b_saida_dados, 32'hC2);
      checar("b_beat2_canal", b_saida_canal, 1);
      checar("b_beat2_ultimo", b_saida_ultimo, 1);
      checar("b_idle_pronto", b_entrada_pronto, 0);
      b_entrada_valido = 3'b001;
      ciclo_tb();
      checar("b_grant0_pronto", b_entrada_pronto, 3'b001);
      ciclo_tb();
      checar("b_beat3_dados", b_saida_dados, 32'hD0);
      checar("b_beat3_canal", b_saida_canal, 0);
      b_entrada_valido = '0;
      ciclo_tb();

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
